trig_mem_resp: RTL and testbench
================================

# trig_mem_resp

Trigger-pattern memory responder: the storage end of the trigger read interface. It answers the 1-bit read-enable / 12-bit read-address stream from the trigger sequencer with 16-bit trigger words, at a fixed 2-cycle latency. A control-register load window fills it with sequential writes. It sits between the control-register write path and the trigger sequencer in the top CDT.

## Interface
- ADDR_W, 12, read/write address width
- DATA_W, 16, trigger word width
- DEPTH, 4096, number of words (2^ADDR_W)
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- ena_load  input  1  control reg; high opens the load window
- in_we  input  1  write strobe, honoured only in LOAD
- in_waddr  input  ADDR_W  write address; must equal out_fill_cnt
- in_wdata  input  DATA_W  write data
- in_rena  input  1  read enable from the trigger sequencer
- in_raddr  input  ADDR_W  read address from the trigger sequencer
- out_rvalid  output  1  out_rdata valid this cycle
- out_rdata  output  DATA_W  returned trigger word
- out_fill_cnt  output  ADDR_W+1  words loaded, 0..4096
- out_busy  output  1  state is SERVE or the read pipeline is non-empty
- out_err_wr  output  1  sticky: write dropped
- out_err_rd  output  1  sticky: read rejected or out of range
- out_err_par  output  1  sticky: parity mismatch (see Configuration)

## Operation
- States: IDLE, LOAD, READY, SERVE. Reset state is IDLE.
- IDLE -> LOAD on a rising edge of ena_load, detected against a registered copy of ena_load.
  - Clears out_fill_cnt and all sticky errors.
- LOAD:
  - When in_we is high, in_waddr == out_fill_cnt, and out_fill_cnt < DEPTH: write the word and increment out_fill_cnt.
  - Any other in_we: word dropped, out_err_wr set.
  - Falling edge of ena_load: -> READY if out_fill_cnt > 0, else -> IDLE.
- READY -> SERVE when in_rena is high.
- SERVE:
  - Every cycle with in_rena high issues one read.
  - -> READY when in_rena is low and the read pipeline is empty.
- Rising edge of ena_load in READY or SERVE -> LOAD.
  - Reads already in flight still complete with their old data.
- Read from IDLE or LOAD: no data issued, out_rvalid stays 0, out_err_rd set.
- Read with in_raddr >= out_fill_cnt: out_rvalid pulses, out_rdata = 0, out_err_rd set.
- Address wrap: 4095 followed by 0 needs no special handling; both are valid when the memory is full.
- Sticky errors hold until the next LOAD entry or reset.

## Timing
- Read latency is 2 cycles.
  - in_rena sampled at edge N; memory registered at N+1; output register at N+2.
  - out_rvalid is high from edge N+2 to N+3.
- Back-to-back reads give one word per cycle, with no bubbles.
- out_fill_cnt updates at the edge after the accepted write.
- Reset values: out_rvalid 0, out_rdata 0, out_fill_cnt 0, out_busy 0, all error flags 0, state IDLE.
- Memory contents are not reset.
- Reset mid-operation: in-flight reads are discarded; no out_rvalid follows reset.

## Configuration
- TRIG_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed at write.
  - Parity is checked at the output stage; a mismatch sets out_err_par.
  - out_rdata still carries the stored data.
- TRIG_MEM_PARITY_EN undefined: no parity storage or check; out_err_par is tied 0.

## Structure
- Shared package trig_pkg holds:
  - ADDR_W/DATA_W/DEPTH constants
  - state enum trig_mem_state_t (IDLE, LOAD, READY, SERVE)
  - fill-count type
- One sub-module, trig_mem_ram: simple dual-port RAM, one write port and one registered read port, width DATA_W (+1 with parity).
- Top holds the FSM, counters, range check and output register.

## Test plan
- Load 4 sequential words 0xA000..0xA003, drop ena_load, read addresses 0..3 back-to-back -> out_rdata 0xA000..0xA003 on 4 consecutive cycles, 2 cycles after each read; out_fill_cnt = 4.
- Write out of order (in_waddr = 5 while out_fill_cnt = 2) -> word dropped, out_err_wr = 1, out_fill_cnt stays 2.
- Fill 4096 words, then issue one more write -> out_err_wr = 1; read 4095 then 0 -> both valid with the stored data.
- Read address 10 with out_fill_cnt = 4 -> out_rvalid pulses, out_rdata = 0, out_err_rd = 1. Read in IDLE -> no out_rvalid, out_err_rd = 1.
- Assert rst_n low one cycle after in_rena -> no out_rvalid afterwards; all outputs 0, state IDLE.
- With TRIG_MEM_PARITY_EN, force a flipped stored bit -> out_err_par = 1 on that read. Without the macro -> out_err_par stays 0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared constants and types for the trigger-pattern memory responder.
package trig_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W:0] fill_t;
  localparam fill_t FILL_MAX = fill_t'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY, SERVE} trig_mem_state_t;
endpackage

// File: rtl/trig_mem_ram.sv
// Simple dual-port trigger RAM: one write port, one registered read port.
module trig_mem_ram #(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [1 << AW];
  logic [W-1:0] rdata_q;

  // Contents and read register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/trig_mem_resp.sv
// Trigger-pattern memory responder: load window fills the RAM, sequencer reads at 2-cycle latency.
// Optional TRIG_MEM_PARITY_EN adds a stored even-parity bit checked at the output stage.
//
// state | meaning
// IDLE  | no valid contents, reads rejected
// LOAD  | load window open, sequential writes accepted
// READY | contents valid, waiting for a read
// SERVE | reads streaming or still in flight
module trig_mem_resp
  import trig_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_load,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_rena,
  input  logic [ADDR_W-1:0] in_raddr,
  output logic              out_rvalid,
  output logic [DATA_W-1:0] out_rdata,
  output fill_t             out_fill_cnt,
  output logic              out_busy,
  output logic              out_err_wr,
  output logic              out_err_rd,
  output logic              out_err_par
);
`ifdef TRIG_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int RAM_W = DATA_W + PAR_W;

  trig_mem_state_t   state_q, state_d;
  logic              ena_q;
  fill_t             fill_q, fill_d;
  logic              err_wr_q, err_wr_d, err_rd_q, err_rd_d;
  logic              rd0_q, rd0_d, oor0_q, oor0_d, rd1_q, oor1_q;
  logic [ADDR_W-1:0] raddr0_q, raddr0_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [RAM_W-1:0]  ram_wdata, ram_rdata;
  logic              rise, fall, serving, in_range, wr_ok, pipe_busy;

`ifdef TRIG_MEM_PARITY_EN
  assign ram_wdata = {^in_wdata, in_wdata};
`else
  assign ram_wdata = in_wdata;
`endif

  trig_mem_ram #(.W(RAM_W), .AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (in_waddr),
    .wdata (ram_wdata),
    .raddr (raddr0_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    rise      = ena_load & ~ena_q;
    fall      = ~ena_load & ena_q;
    serving   = (state_q == READY) || (state_q == SERVE);
    in_range  = {1'b0, in_raddr} < fill_q;
    wr_ok     = (state_q == LOAD) && in_we && ({1'b0, in_waddr} == fill_q) && (fill_q < FILL_MAX);
    pipe_busy = rd0_q | oor0_q | rd1_q | oor1_q;

    state_d  = state_q;
    fill_d   = wr_ok ? fill_q + fill_t'(1) : fill_q;
    err_wr_d = err_wr_q | ((state_q == LOAD) && in_we && !wr_ok);
    err_rd_d = err_rd_q | (in_rena && (!serving || !in_range));
    rd0_d    = in_rena && serving && in_range;
    oor0_d   = in_rena && serving && !in_range;
    raddr0_d = in_raddr;
    rvalid_d = rd1_q | oor1_q;
    rdata_d  = rd1_q ? ram_rdata[DATA_W-1:0] : '0;

    unique case (state_q)
      IDLE:    if (rise) state_d = LOAD;
      LOAD:    if (fall) state_d = (fill_d != '0) ? READY : IDLE;
      READY:   if (rise) state_d = LOAD;
               else if (in_rena) state_d = SERVE;
      SERVE:   if (rise) state_d = LOAD;
               else if (!in_rena && !pipe_busy) state_d = READY;
      default: state_d = IDLE;
    endcase

    // Entering the load window restarts the fill and clears the sticky errors.
    if (state_d == LOAD && state_q != LOAD) begin
      fill_d   = '0;
      err_wr_d = 1'b0;
      err_rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ena_q    <= 1'b0;
      fill_q   <= '0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
      rd0_q    <= 1'b0;
      oor0_q   <= 1'b0;
      raddr0_q <= '0;
      rd1_q    <= 1'b0;
      oor1_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ena_q    <= ena_load;
      fill_q   <= fill_d;
      err_wr_q <= err_wr_d;
      err_rd_q <= err_rd_d;
      rd0_q    <= rd0_d;
      oor0_q   <= oor0_d;
      raddr0_q <= raddr0_d;
      rd1_q    <= rd0_q;
      oor1_q   <= oor0_q;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef TRIG_MEM_PARITY_EN
  logic err_par_q, err_par_d;

  always_comb begin
    err_par_d = err_par_q | (rd1_q & (^ram_rdata));
    if (state_d == LOAD && state_q != LOAD) err_par_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_par_q <= 1'b0;
    else        err_par_q <= err_par_d;
  end

  assign out_err_par = err_par_q;
`else
  assign out_err_par = 1'b0;
`endif

  assign out_rvalid   = rvalid_q;
  assign out_rdata    = rdata_q;
  assign out_fill_cnt = fill_q;
  assign out_busy     = (state_q == SERVE) | pipe_busy;
  assign out_err_wr   = err_wr_q;
  assign out_err_rd   = err_rd_q;
endmodule

// File: tb/tb_trig_mem_resp.sv
// Scoreboard bench for trig_mem_resp: expected read words queued at issue, checked on out_rvalid.
module tb_trig_mem_resp;
  import trig_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena_load = 1'b0;
  logic              in_we = 1'b0;
  logic [ADDR_W-1:0] in_waddr = '0;
  logic [DATA_W-1:0] in_wdata = '0;
  logic              in_rena = 1'b0;
  logic [ADDR_W-1:0] in_raddr = '0;
  logic              out_rvalid;
  logic [DATA_W-1:0] out_rdata;
  fill_t             out_fill_cnt;
  logic              out_busy, out_err_wr, out_err_rd, out_err_par;

  trig_mem_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena_load     (ena_load),
    .in_we        (in_we),
    .in_waddr     (in_waddr),
    .in_wdata     (in_wdata),
    .in_rena      (in_rena),
    .in_raddr     (in_raddr),
    .out_rvalid   (out_rvalid),
    .out_rdata    (out_rdata),
    .out_fill_cnt (out_fill_cnt),
    .out_busy     (out_busy),
    .out_err_wr   (out_err_wr),
    .out_err_rd   (out_err_rd),
    .out_err_par  (out_err_par)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                cyc = 0;
  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_fill = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every returned word must match the oldest expectation, on exactly its due cycle.
  always @(negedge clk) begin
    if (rst_n && out_rvalid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid: out_rvalid=1 rdata=%h at cycle %0d, required no read outstanding", out_rdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_rdata !== mon_e.data || cyc != mon_e.due) begin
          miscompares++;
          $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d", out_rdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena_load = 1'b0; in_we = 1'b0; in_rena = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_fill = 0;
    tick();
  endtask

  task automatic open_load();
    ena_load = 1'b1;
    tick();
    m_fill = 0;
  endtask

  task automatic close_load();
    ena_load = 1'b0;
    tick(); tick();
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] data);
    in_we = 1'b1; in_waddr = ADDR_W'(addr); in_wdata = data;
    if (addr == m_fill && m_fill < DEPTH) begin
      m_mem[addr] = data;
      m_fill++;
    end
    tick();
    in_we = 1'b0;
  endtask

  // Issue one read; the word is due three negedges after the one this is driven from.
  task automatic rd(input int addr);
    exp_t e;
    in_rena = 1'b1; in_raddr = ADDR_W'(addr);
    e.data = (addr < m_fill) ? m_mem[addr] : '0;
    e.due  = cyc + 3;
    exp_q.push_back(e);
    tick();
    in_rena = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    vectors += 8;
    if (out_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b, required 0", out_rvalid); end
    if (out_rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h, required 0", out_rdata); end
    if (out_fill_cnt !== '0) begin miscompares++; $display("FAIL reset_fill: got %0d, required 0", out_fill_cnt); end
    if (out_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", out_busy); end
    if (out_err_wr !== 1'b0) begin miscompares++; $display("FAIL reset_err_wr: got %b, required 0", out_err_wr); end
    if (out_err_rd !== 1'b0) begin miscompares++; $display("FAIL reset_err_rd: got %b, required 0", out_err_rd); end
    if (out_err_par !== 1'b0) begin miscompares++; $display("FAIL reset_err_par: got %b, required 0", out_err_par); end
    if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q); end
  endtask

  task automatic test_basic();
    open_load();
    for (int i = 0; i < 4; i++) wr(i, 16'hA000 + 16'(i));
    close_load();
    vectors++;
    if (out_fill_cnt !== fill_t'(4)) begin miscompares++; $display("FAIL basic_fill: got %0d, required 4", out_fill_cnt); end
    for (int i = 0; i < 4; i++) rd(i);
    vectors++;
    if (out_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_active: got %b, required 1", out_busy); end
    drain("basic");
    vectors += 3;
    if (out_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle: got %b, required 0", out_busy); end
    if (out_err_rd !== 1'b0) begin miscompares++; $display("FAIL basic_err_rd: got %b, required 0", out_err_rd); end
    if (out_err_wr !== 1'b0) begin miscompares++; $display("FAIL basic_err_wr: got %b, required 0", out_err_wr); end
  endtask

  task automatic test_out_of_range();
    rd(10);
    drain("oor");
    vectors++;
    if (out_err_rd !== 1'b1) begin miscompares++; $display("FAIL oor_err_rd: got %b, required 1", out_err_rd); end
  endtask

  task automatic test_reload_inflight();
    rd(2);
    ena_load = 1'b1;
    tick();
    m_fill = 0;
    wr(0, 16'hC000);
    wr(1, 16'hC001);
    wr(2, 16'hC002);
    drain("reload");
    vectors += 2;
    if (out_fill_cnt !== fill_t'(3)) begin miscompares++; $display("FAIL reload_fill: got %0d, required 3", out_fill_cnt); end
    if (out_err_rd !== 1'b0) begin miscompares++; $display("FAIL reload_err_clear: got %b, required 0", out_err_rd); end
    close_load();
    for (int i = 0; i < 3; i++) rd(i);
    drain("reload_read");
  endtask

  task automatic test_out_of_order();
    open_load();
    wr(0, 16'h1111);
    wr(1, 16'h2222);
    wr(5, 16'hBAD5);
    vectors += 2;
    if (out_fill_cnt !== fill_t'(2)) begin miscompares++; $display("FAIL ooo_fill: got %0d, required 2", out_fill_cnt); end
    if (out_err_wr !== 1'b1) begin miscompares++; $display("FAIL ooo_err_wr: got %b, required 1", out_err_wr); end
    wr(2, 16'h3333);
    close_load();
    for (int i = 0; i < 3; i++) rd(i);
    rd(5);
    drain("ooo");
  endtask

  task automatic test_idle_read();
    open_load();
    close_load();
    in_rena = 1'b1; in_raddr = '0;
    tick();
    in_rena = 1'b0;
    repeat (5) tick();
    vectors += 2;
    if (out_err_rd !== 1'b1) begin miscompares++; $display("FAIL idle_err_rd: got %b, required 1", out_err_rd); end
    if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL idle_state: got %0d, required IDLE", dut.state_q); end
  endtask

  task automatic test_reset_midflight();
    open_load();
    for (int i = 0; i < 4; i++) wr(i, 16'hB000 + 16'(i));
    close_load();
    in_rena = 1'b1; in_raddr = 12'd1;
    tick();
    in_rena = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_fill = 0;
    repeat (6) tick();
    vectors += 5;
    if (out_rvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_rvalid: got %b, required 0", out_rvalid); end
    if (out_rdata !== '0) begin miscompares++; $display("FAIL midrst_rdata: got %h, required 0", out_rdata); end
    if (out_fill_cnt !== '0) begin miscompares++; $display("FAIL midrst_fill: got %0d, required 0", out_fill_cnt); end
    if (out_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", out_busy); end
    if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL midrst_state: got %0d, required IDLE", dut.state_q); end
  endtask

  task automatic test_full();
    open_load();
    for (int i = 0; i < DEPTH; i++) wr(i, 16'(i * 7 + 3) ^ 16'h5A00);
    vectors += 2;
    if (out_err_wr !== 1'b0) begin miscompares++; $display("FAIL full_err_wr_pre: got %b, required 0", out_err_wr); end
    if (out_fill_cnt !== FILL_MAX) begin miscompares++; $display("FAIL full_fill: got %0d, required 4096", out_fill_cnt); end
    wr(0, 16'hDEAD);
    vectors += 2;
    if (out_err_wr !== 1'b1) begin miscompares++; $display("FAIL full_err_wr: got %b, required 1", out_err_wr); end
    if (out_fill_cnt !== FILL_MAX) begin miscompares++; $display("FAIL full_fill_post: got %0d, required 4096", out_fill_cnt); end
    close_load();
    rd(DEPTH - 1);
    rd(0);
    drain("wrap");
    vectors++;
    if (out_err_rd !== 1'b0) begin miscompares++; $display("FAIL wrap_err_rd: got %b, required 0", out_err_rd); end
  endtask

  task automatic test_parity();
`ifdef TRIG_MEM_PARITY_EN
    rd(7);
    drain("par_clean");
    vectors++;
    if (out_err_par !== 1'b0) begin miscompares++; $display("FAIL par_clean: got %b, required 0", out_err_par); end
    dut.u_ram.mem_q[7][3] = ~dut.u_ram.mem_q[7][3];
    m_mem[7] = m_mem[7] ^ 16'h0008;
    rd(7);
    drain("par_flip");
    vectors++;
    if (out_err_par !== 1'b1) begin miscompares++; $display("FAIL par_flip: got %b, required 1", out_err_par); end
`else
    rd(7);
    drain("par_off");
    vectors++;
    if (out_err_par !== 1'b0) begin miscompares++; $display("FAIL par_off: got %b, required 0", out_err_par); end
`endif
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_out_of_range();
    test_reload_inflight();
    test_out_of_order();
    test_idle_read();
    test_reset_midflight();
    test_full();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
